// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO controller: TX state encoding,
// status register bit positions and the memory-mapped register addresses.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_e;

  localparam int STAT_RX_READY   = 0;
  localparam int STAT_RX_OVERRUN = 1;
  localparam int STAT_TX_BUSY    = 2;
  localparam int STAT_TX_PENDING = 3;
  localparam int STAT_BITS       = 4;

  localparam logic [31:0] ADDR_TX_CMD    = 32'h1001_0024;
  localparam logic [31:0] ADDR_TX_DATA   = 32'h1001_0028;
  localparam logic [31:0] ADDR_RX_DATA   = 32'h1001_002C;
  localparam logic [31:0] ADDR_RX_STATUS = 32'h1001_0030;
  localparam logic [31:0] ADDR_RX_CLEAR  = 32'h1001_0034;

  function automatic logic [STAT_BITS-1:0] pack_status(
    input logic rx_ready,
    input logic rx_overrun,
    input logic tx_busy,
    input logic tx_pending
  );
    logic [STAT_BITS-1:0] s;
    s                  = '0;
    s[STAT_RX_READY]   = rx_ready;
    s[STAT_RX_OVERRUN] = rx_overrun;
    s[STAT_TX_BUSY]    = tx_busy;
    s[STAT_TX_PENDING] = tx_pending;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_hold.sv
// Single-entry holding register for received UART bytes with ready and
// overrun flags; the first byte is kept until software clears it.
module uart_rx_hold #(
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [BYTE_WIDTH-1:0] rx_byte,
  input  logic                  clear,
  output logic [BYTE_WIDTH-1:0] hold_byte,
  output logic                  rx_ready,
  output logic                  rx_overrun
);

  logic [BYTE_WIDTH-1:0] byte_q, byte_d;
  logic                  ready_q, ready_d;
  logic                  overrun_q, overrun_d;

  // A clear in the same cycle as a new byte frees the slot first, so the byte is taken.
  always_comb begin
    byte_d    = byte_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (rx_valid && (!ready_q || clear)) begin
      byte_d    = rx_byte;
      ready_d   = 1'b1;
      overrun_d = 1'b0;
    end else if (rx_valid) begin
      overrun_d = 1'b1;
    end else if (clear) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      byte_q    <= byte_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign hold_byte  = byte_q;
  assign rx_ready   = ready_q;
  assign rx_overrun = overrun_q;

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for a UART: TX command/data registers driving a serializer
// handshake, plus RX holding register and a status word for the core.
//
// state        | meaning
// TX_IDLE      | no transfer; a send request or pending flag starts one
// TX_START     | uart_tx_start high for this single cycle
// TX_WAIT_DONE | serializer busy, waiting for uart_tx_done
module uart_mmio_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  Tx_MemWrite,
  input  logic                  Tx_data_Memwrite,
  input  logic                  Clean_rx_Memwrite,
  output logic [DATA_WIDTH-1:0] Rx_ReadData,
  output logic [DATA_WIDTH-1:0] Rx_ready_ReadData,
  output logic                  uart_tx_start,
  output logic [BYTE_WIDTH-1:0] uart_tx_byte,
  input  logic                  uart_tx_done,
  input  logic                  uart_rx_valid,
  input  logic [BYTE_WIDTH-1:0] uart_rx_byte
);
  import uart_mmio_pkg::*;

  tx_state_e             state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  tx_start_q, tx_start_d;
  logic [BYTE_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [BYTE_WIDTH-1:0] tx_byte_q, tx_byte_d;

  logic                  send_req;
  logic                  clear_req;
  logic [BYTE_WIDTH-1:0] rx_hold_byte;
  logic                  rx_ready;
  logic                  rx_overrun;
  logic                  tx_busy;
  logic                  unused_wdata;

  assign send_req     = Tx_MemWrite & WriteData[0];
  assign clear_req    = Clean_rx_Memwrite & WriteData[0];
  assign unused_wdata = ^WriteData[DATA_WIDTH-1:BYTE_WIDTH];

  // uart_tx_byte is captured only when entering START, so data writes mid-transfer are safe.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    tx_data_d  = Tx_data_Memwrite ? WriteData[BYTE_WIDTH-1:0] : tx_data_q;
    case (state_q)
      TX_IDLE: begin
        if (send_req || pending_q) begin
          state_d    = TX_START;
          tx_start_d = 1'b1;
          tx_byte_d  = tx_data_q;
          pending_d  = 1'b0;
        end
      end
      TX_START: begin
        state_d = TX_WAIT_DONE;
        if (send_req) pending_d = 1'b1;
      end
      TX_WAIT_DONE: begin
        if (uart_tx_done) state_d = TX_IDLE;
        if (send_req) pending_d = 1'b1;
      end
      default: begin
        state_d   = TX_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TX_IDLE;
      pending_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  uart_rx_hold #(
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_rx_hold (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (uart_rx_valid),
    .rx_byte   (uart_rx_byte),
    .clear     (clear_req),
    .hold_byte (rx_hold_byte),
    .rx_ready  (rx_ready),
    .rx_overrun(rx_overrun)
  );

  assign tx_busy       = (state_q != TX_IDLE);
  assign uart_tx_start = tx_start_q;
  assign uart_tx_byte  = tx_byte_q;

  assign Rx_ReadData       = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, rx_hold_byte};
  assign Rx_ready_ReadData = {{(DATA_WIDTH-STAT_BITS){1'b0}},
                              pack_status(rx_ready, rx_overrun, tx_busy, pending_q)};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: stimulus queues expected TX starts and
// register reads, an independent monitor pops and compares them.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WriteData;
  logic        Tx_MemWrite;
  logic        Tx_data_Memwrite;
  logic        Clean_rx_Memwrite;
  logic [31:0] Rx_ReadData;
  logic [31:0] Rx_ready_ReadData;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_byte;
  logic        uart_tx_done;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_byte;

  uart_mmio_ctrl #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .WriteData        (WriteData),
    .Tx_MemWrite      (Tx_MemWrite),
    .Tx_data_Memwrite (Tx_data_Memwrite),
    .Clean_rx_Memwrite(Clean_rx_Memwrite),
    .Rx_ReadData      (Rx_ReadData),
    .Rx_ready_ReadData(Rx_ready_ReadData),
    .uart_tx_start    (uart_tx_start),
    .uart_tx_byte     (uart_tx_byte),
    .uart_tx_done     (uart_tx_done),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_byte     (uart_rx_byte)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] b;
    int         at;
  } tx_exp_t;

  typedef struct {
    logic [31:0] st;
    logic [31:0] dat;
    logic [7:0]  txb;
    string       tag;
  } rd_exp_t;

  tx_exp_t tx_q[$];
  rd_exp_t rd_q[$];
  logic    rd_req = 1'b0;

  // Monitor: samples 1 time unit after the falling edge.
  initial begin
    tx_exp_t te;
    rd_exp_t re;
    forever begin
      @(negedge clk);
      #1;
      if (uart_tx_start === 1'b1) begin
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: got start with byte %h at cycle %0d, required no start",
                   uart_tx_byte, cyc);
        end else begin
          te = tx_q.pop_front();
          if (uart_tx_byte !== te.b || cyc != te.at) begin
            errors++;
            $display("FAIL tx_start: got byte %h at cycle %0d, required byte %h at cycle %0d",
                     uart_tx_byte, cyc, te.b, te.at);
          end
        end
      end
      if (rd_req === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL read_queue: read strobe with no expectation queued");
        end else begin
          re = rd_q.pop_front();
          if (Rx_ready_ReadData !== re.st || Rx_ReadData !== re.dat || uart_tx_byte !== re.txb) begin
            errors++;
            $display("FAIL %s: got status %h data %h txbyte %h, required status %h data %h txbyte %h",
                     re.tag, Rx_ready_ReadData, Rx_ReadData, uart_tx_byte, re.st, re.dat, re.txb);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [31:0] st, input logic [31:0] dat,
                    input logic [7:0] txb);
    rd_exp_t e;
    e.st = st; e.dat = dat; e.txb = txb; e.tag = tag;
    rd_q.push_back(e);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wr_data(input logic [7:0] b);
    Tx_data_Memwrite = 1'b1;
    WriteData        = {24'h0, b};
    @(negedge clk);
    Tx_data_Memwrite = 1'b0;
    WriteData        = '0;
  endtask

  task automatic send(input logic [31:0] wd, input bit expect_start, input logic [7:0] b);
    tx_exp_t e;
    if (expect_start) begin
      e.b = b; e.at = cyc + 1;
      tx_q.push_back(e);
    end
    Tx_MemWrite = 1'b1;
    WriteData   = wd;
    @(negedge clk);
    Tx_MemWrite = 1'b0;
    WriteData   = '0;
  endtask

  // Done pulse; optionally a pending request restarts two edges later.
  task automatic done(input bit with_send, input bit expect_restart, input logic [7:0] b);
    tx_exp_t e;
    if (expect_restart) begin
      e.b = b; e.at = cyc + 2;
      tx_q.push_back(e);
    end
    uart_tx_done = 1'b1;
    if (with_send) begin
      Tx_MemWrite = 1'b1;
      WriteData   = 32'h1;
    end
    @(negedge clk);
    uart_tx_done = 1'b0;
    Tx_MemWrite  = 1'b0;
    WriteData    = '0;
  endtask

  task automatic rx(input logic [7:0] b, input bit with_clear, input logic [31:0] wd);
    uart_rx_valid     = 1'b1;
    uart_rx_byte      = b;
    Clean_rx_Memwrite = with_clear;
    WriteData         = wd;
    @(negedge clk);
    uart_rx_valid     = 1'b0;
    uart_rx_byte      = '0;
    Clean_rx_Memwrite = 1'b0;
    WriteData         = '0;
  endtask

  task automatic clr(input logic [31:0] wd);
    Clean_rx_Memwrite = 1'b1;
    WriteData         = wd;
    @(negedge clk);
    Clean_rx_Memwrite = 1'b0;
    WriteData         = '0;
  endtask

  initial begin
    reset             = 1'b0;
    WriteData         = '0;
    Tx_MemWrite       = 1'b0;
    Tx_data_Memwrite  = 1'b0;
    Clean_rx_Memwrite = 1'b0;
    uart_tx_done      = 1'b0;
    uart_rx_valid     = 1'b0;
    uart_rx_byte      = '0;
    repeat (2) step();
    rd("reset_state", 32'h0, 32'h0, 8'h00);
    reset = 1'b1;
    step();

    // Single send
    wr_data(8'h41);
    send(32'h1, 1'b1, 8'h41);
    rd("t1_start", 32'h4, 32'h0, 8'h41);
    rd("t1_wait", 32'h4, 32'h0, 8'h41);
    done(1'b0, 1'b0, 8'h00);
    rd("t1_done", 32'h0, 32'h0, 8'h41);

    // Send while busy: one pending, extra request dropped, byte not disturbed
    wr_data(8'h41);
    send(32'h1, 1'b1, 8'h41);
    wr_data(8'h42);
    send(32'h1, 1'b0, 8'h00);
    send(32'h1, 1'b0, 8'h00);
    rd("t2_pending", 32'hC, 32'h0, 8'h41);
    done(1'b0, 1'b1, 8'h42);
    rd("t2_idle_pending", 32'h8, 32'h0, 8'h41);
    rd("t2_second", 32'h4, 32'h0, 8'h42);
    done(1'b0, 1'b0, 8'h00);
    rd("t2_end", 32'h0, 32'h0, 8'h42);

    // Done and new request in the same cycle keep the request
    send(32'h1, 1'b1, 8'h42);
    step();
    done(1'b1, 1'b1, 8'h42);
    rd("t3_pending", 32'h8, 32'h0, 8'h42);
    rd("t3_restart", 32'h4, 32'h0, 8'h42);
    done(1'b0, 1'b0, 8'h00);
    rd("t3_end", 32'h0, 32'h0, 8'h42);

    // Receive and overrun
    rx(8'h55, 1'b0, 32'h0);
    rd("rx_first", 32'h1, 32'h55, 8'h42);
    rx(8'hAA, 1'b0, 32'h0);
    rd("rx_overrun", 32'h3, 32'h55, 8'h42);

    // Clear together with a new byte, then ignored and real clears
    rx(8'h33, 1'b1, 32'h1);
    rd("rx_clear_valid", 32'h1, 32'h33, 8'h42);
    clr(32'h0);
    rd("rx_clear_bit0_low", 32'h1, 32'h33, 8'h42);
    clr(32'h1);
    rd("rx_clear", 32'h0, 32'h33, 8'h42);

    // Reset during WAIT_DONE, then a stray done
    wr_data(8'h77);
    send(32'h1, 1'b1, 8'h77);
    step();
    reset = 1'b0;
    step();
    rd("reset_mid_xfer", 32'h0, 32'h0, 8'h00);
    reset = 1'b1;
    done(1'b0, 1'b0, 8'h00);
    repeat (5) step();
    rd("after_stray_done", 32'h0, 32'h0, 8'h00);

    // Send command with bit0 low does nothing
    wr_data(8'h5A);
    send(32'h0, 1'b0, 8'h00);
    repeat (10) step();
    rd("no_send_bit0_low", 32'h0, 32'h0, 8'h00);

    step();
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL tx_queue_drained: got %0d outstanding starts, required 0", tx_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
